// File: rtl/fpu_cpu_interface_pkg.sv
// rtl/fpu_cpu_interface_pkg.sv - shared types and constants for the CPU/FPU escape-opcode bridge
package fpu_if_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT_DATA,
        EXECUTE,
        WAIT_DONE
    } fpu_state_e;

    localparam logic [15:0] CW_RESET = 16'h037F;

    // An error only raises an exception if at least one flagged condition is unmasked in the CW.
    function automatic logic unmasked_fault(input logic [15:0] status, input logic [15:0] cw);
        return |(status[5:0] & ~cw[5:0]);
    endfunction

endpackage

// File: rtl/fpu_cpu_interface_if.sv
// rtl/fpu_cpu_interface_if.sv - CPU-side and core-side signal bundle of the FPU bridge
interface fpu_cpu_interface_if;

    logic        cpu_fpu_instr_valid;
    logic [7:0]  cpu_fpu_opcode;
    logic [7:0]  cpu_fpu_modrm;
    logic        cpu_fpu_instr_ack;
    logic        cpu_fpu_has_memory_op;
    logic [1:0]  cpu_fpu_operand_size;
    logic        cpu_fpu_is_integer;
    logic        cpu_fpu_is_bcd;
    logic        cpu_fpu_data_write;
    logic        cpu_fpu_data_read;
    logic [2:0]  cpu_fpu_data_size;
    logic [79:0] cpu_fpu_data_in;
    logic [79:0] cpu_fpu_data_out;
    logic        cpu_fpu_data_ready;
    logic        cpu_fpu_busy;
    logic        cpu_fpu_ready;
    logic        cpu_fpu_wait;
    logic [15:0] cpu_fpu_status_word;
    logic        cpu_fpu_exception;
    logic        cpu_fpu_irq;
    logic [15:0] cpu_fpu_control_word;
    logic        cpu_fpu_ctrl_write;

    logic        fpu_start;
    logic [7:0]  fpu_operation;
    logic [7:0]  fpu_operand_select;
    logic [79:0] fpu_operand_data;
    logic        fpu_has_memory_op;
    logic [1:0]  fpu_operand_size;
    logic        fpu_is_integer;
    logic        fpu_is_bcd;
    logic        fpu_operation_complete;
    logic [79:0] fpu_result_data;
    logic [15:0] fpu_status;
    logic        fpu_error;
    logic [15:0] fpu_control_reg;
    logic        fpu_control_update;

    modport slave (
        input  cpu_fpu_instr_valid, cpu_fpu_opcode, cpu_fpu_modrm,
        input  cpu_fpu_has_memory_op, cpu_fpu_operand_size, cpu_fpu_is_integer, cpu_fpu_is_bcd,
        input  cpu_fpu_data_write, cpu_fpu_data_read, cpu_fpu_data_size, cpu_fpu_data_in,
        input  cpu_fpu_wait, cpu_fpu_control_word, cpu_fpu_ctrl_write,
        input  fpu_operation_complete, fpu_result_data, fpu_status, fpu_error,
        output cpu_fpu_instr_ack, cpu_fpu_data_out, cpu_fpu_data_ready,
        output cpu_fpu_busy, cpu_fpu_ready, cpu_fpu_status_word, cpu_fpu_exception, cpu_fpu_irq,
        output fpu_start, fpu_operation, fpu_operand_select, fpu_operand_data,
        output fpu_has_memory_op, fpu_operand_size, fpu_is_integer, fpu_is_bcd,
        output fpu_control_reg, fpu_control_update
    );

    modport master (
        output cpu_fpu_instr_valid, cpu_fpu_opcode, cpu_fpu_modrm,
        output cpu_fpu_has_memory_op, cpu_fpu_operand_size, cpu_fpu_is_integer, cpu_fpu_is_bcd,
        output cpu_fpu_data_write, cpu_fpu_data_read, cpu_fpu_data_size, cpu_fpu_data_in,
        output cpu_fpu_wait, cpu_fpu_control_word, cpu_fpu_ctrl_write,
        output fpu_operation_complete, fpu_result_data, fpu_status, fpu_error,
        input  cpu_fpu_instr_ack, cpu_fpu_data_out, cpu_fpu_data_ready,
        input  cpu_fpu_busy, cpu_fpu_ready, cpu_fpu_status_word, cpu_fpu_exception, cpu_fpu_irq,
        input  fpu_start, fpu_operation, fpu_operand_select, fpu_operand_data,
        input  fpu_has_memory_op, fpu_operand_size, fpu_is_integer, fpu_is_bcd,
        input  fpu_control_reg, fpu_control_update
    );

endinterface

// File: rtl/fpu_cpu_interface.sv
// rtl/fpu_cpu_interface.sv - one-instruction-at-a-time handshake bridge between CPU escape path and FPU core
module fpu_cpu_interface
    import fpu_if_pkg::*;
#(
    parameter logic [15:0] CW_RESET_VAL = CW_RESET
) (
    input  logic                 clk,
    input  logic                 reset,
    fpu_cpu_interface_if.slave   bus
);

    fpu_state_e  state, state_next;

    logic        instr_ack_q;
    logic [7:0]  operation_q;
    logic [7:0]  operand_select_q;
    logic [79:0] operand_data_q;
    logic        has_mem_q;
    logic [1:0]  operand_size_q;
    logic        is_integer_q;
    logic        is_bcd_q;
    logic [79:0] data_out_q;
    logic        data_ready_q;
    logic [15:0] status_word_q;
    logic        exception_q;
    logic [15:0] control_q;
    logic        control_update_q;

    // WAIT is only meaningful to the CPU and the transfer size is implied by the latched format.
    logic        unused_inputs;
    assign unused_inputs = &{1'b0, bus.cpu_fpu_wait, bus.cpu_fpu_data_size};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.cpu_fpu_instr_valid)    state_next = DECODE;
            DECODE:    state_next = has_mem_q ? WAIT_DATA : EXECUTE;
            WAIT_DATA: if (bus.cpu_fpu_data_write)     state_next = EXECUTE;
            EXECUTE:   state_next = WAIT_DONE;
            WAIT_DONE: if (bus.fpu_operation_complete) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_ack_q      <= 1'b0;
            operation_q      <= '0;
            operand_select_q <= '0;
            operand_data_q   <= '0;
            has_mem_q        <= 1'b0;
            operand_size_q   <= '0;
            is_integer_q     <= 1'b0;
            is_bcd_q         <= 1'b0;
            data_out_q       <= '0;
            data_ready_q     <= 1'b0;
            status_word_q    <= '0;
            exception_q      <= 1'b0;
            control_q        <= CW_RESET_VAL;
            control_update_q <= 1'b0;
        end else begin
            instr_ack_q      <= 1'b0;
            control_update_q <= bus.cpu_fpu_ctrl_write;

            if (state == IDLE && bus.cpu_fpu_instr_valid) begin
                instr_ack_q      <= 1'b1;
                operation_q      <= bus.cpu_fpu_opcode;
                operand_select_q <= bus.cpu_fpu_modrm;
                has_mem_q        <= bus.cpu_fpu_has_memory_op;
                operand_size_q   <= bus.cpu_fpu_operand_size;
                is_integer_q     <= bus.cpu_fpu_is_integer;
                is_bcd_q         <= bus.cpu_fpu_is_bcd;
                data_ready_q     <= 1'b0;
            end

            if (state == WAIT_DATA && bus.cpu_fpu_data_write)
                operand_data_q <= bus.cpu_fpu_data_in;

            if (bus.cpu_fpu_data_read)
                data_ready_q <= 1'b0;

            // A fresh result outranks a same-cycle read of the previous one.
            if (state == WAIT_DONE && bus.fpu_operation_complete) begin
                data_out_q    <= bus.fpu_result_data;
                data_ready_q  <= 1'b1;
                status_word_q <= bus.fpu_status;
                if (bus.fpu_error && unmasked_fault(bus.fpu_status, control_q))
                    exception_q <= 1'b1;
            end

            // Placed last so a CW load always wins the exception clear.
            if (bus.cpu_fpu_ctrl_write) begin
                control_q   <= bus.cpu_fpu_control_word;
                exception_q <= 1'b0;
            end
        end
    end

    assign bus.cpu_fpu_instr_ack   = instr_ack_q;
    assign bus.cpu_fpu_data_out    = data_out_q;
    assign bus.cpu_fpu_data_ready  = data_ready_q;
    assign bus.cpu_fpu_busy        = (state != IDLE);
    assign bus.cpu_fpu_ready       = (state == IDLE);
    assign bus.cpu_fpu_status_word = status_word_q;
    assign bus.cpu_fpu_exception   = exception_q;
    assign bus.cpu_fpu_irq         = exception_q & ~control_q[7];
    assign bus.fpu_start           = (state == EXECUTE);
    assign bus.fpu_operation       = operation_q;
    assign bus.fpu_operand_select  = operand_select_q;
    assign bus.fpu_operand_data    = operand_data_q;
    assign bus.fpu_has_memory_op   = has_mem_q;
    assign bus.fpu_operand_size    = operand_size_q;
    assign bus.fpu_is_integer      = is_integer_q;
    assign bus.fpu_is_bcd          = is_bcd_q;
    assign bus.fpu_control_reg     = control_q;
    assign bus.fpu_control_update  = control_update_q;

endmodule

// File: tb/tb_fpu_cpu_interface.sv
// tb/tb_fpu_cpu_interface.sv - randomized self-checking bench for the FPU bridge against a transaction-level model
module tb_fpu_cpu_interface;
    import fpu_if_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpu_cpu_interface_if bus();

    fpu_cpu_interface dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural view of the bridge: what the CPU should see after each transaction.
    logic [15:0] m_cw;
    logic        m_exc;
    logic [79:0] m_data_out;
    logic [15:0] m_status;
    logic        m_dready;
    logic [7:0]  m_op, m_modrm;
    logic [79:0] m_opnd;
    logic        m_mem, m_int, m_bcd;
    logic [1:0]  m_size;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cpu_fpu_instr_valid    = 1'b0;
        bus.cpu_fpu_opcode         = '0;
        bus.cpu_fpu_modrm          = '0;
        bus.cpu_fpu_has_memory_op  = 1'b0;
        bus.cpu_fpu_operand_size   = '0;
        bus.cpu_fpu_is_integer     = 1'b0;
        bus.cpu_fpu_is_bcd         = 1'b0;
        bus.cpu_fpu_data_write     = 1'b0;
        bus.cpu_fpu_data_read      = 1'b0;
        bus.cpu_fpu_data_size      = '0;
        bus.cpu_fpu_data_in        = '0;
        bus.cpu_fpu_wait           = 1'b0;
        bus.cpu_fpu_control_word   = '0;
        bus.cpu_fpu_ctrl_write     = 1'b0;
        bus.fpu_operation_complete = 1'b0;
        bus.fpu_result_data        = '0;
        bus.fpu_status             = '0;
        bus.fpu_error              = 1'b0;
    endtask

    task automatic model_reset();
        m_cw = 16'h037F; m_exc = 1'b0; m_data_out = '0; m_status = '0; m_dready = 1'b0;
        m_op = '0; m_modrm = '0; m_opnd = '0; m_mem = 1'b0; m_int = 1'b0; m_bcd = 1'b0; m_size = '0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ready"},   bus.cpu_fpu_ready, 1'b1);
        check({tag, ".busy"},    bus.cpu_fpu_busy, 1'b0);
        check({tag, ".start"},   bus.fpu_start, 1'b0);
        check({tag, ".cw"},      bus.fpu_control_reg, m_cw);
        check({tag, ".exc"},     bus.cpu_fpu_exception, m_exc);
        check({tag, ".irq"},     bus.cpu_fpu_irq, m_exc && !m_cw[7]);
        check({tag, ".dout"},    bus.cpu_fpu_data_out, m_data_out);
        check({tag, ".dready"},  bus.cpu_fpu_data_ready, m_dready);
        check({tag, ".status"},  bus.cpu_fpu_status_word, m_status);
    endtask

    task automatic check_format(input string tag);
        check({tag, ".op"},   bus.fpu_operation, m_op);
        check({tag, ".sel"},  bus.fpu_operand_select, m_modrm);
        check({tag, ".mem"},  bus.fpu_has_memory_op, m_mem);
        check({tag, ".size"}, bus.fpu_operand_size, m_size);
        check({tag, ".int"},  bus.fpu_is_integer, m_int);
        check({tag, ".bcd"},  bus.fpu_is_bcd, m_bcd);
    endtask

    task automatic write_cw(input logic [15:0] cw);
        bus.cpu_fpu_control_word = cw;
        bus.cpu_fpu_ctrl_write   = 1'b1;
        tick();
        bus.cpu_fpu_ctrl_write   = 1'b0;
        m_cw = cw; m_exc = 1'b0;
        check("cw.load", bus.fpu_control_reg, cw);
        check("cw.update_pulse", bus.fpu_control_update, 1'b1);
        check("cw.exc_clear", bus.cpu_fpu_exception, 1'b0);
        tick();
        check("cw.update_drop", bus.fpu_control_update, 1'b0);
    endtask

    task automatic read_result();
        bus.cpu_fpu_data_read = 1'b1;
        tick();
        bus.cpu_fpu_data_read = 1'b0;
        m_dready = 1'b0;
        check("read.dready", bus.cpu_fpu_data_ready, 1'b0);
        check("read.dout_hold", bus.cpu_fpu_data_out, m_data_out);
    endtask

    task automatic run_instr(input logic [7:0] op, input logic [7:0] modrm, input logic mem,
                             input logic [1:0] size, input logic isint, input logic isbcd,
                             input logic [79:0] opnd, input logic [79:0] result,
                             input logic [15:0] status, input logic err,
                             input logic cw_same, input logic [15:0] cw_val);
        bus.cpu_fpu_instr_valid   = 1'b1;
        bus.cpu_fpu_opcode        = op;
        bus.cpu_fpu_modrm         = modrm;
        bus.cpu_fpu_has_memory_op = mem;
        bus.cpu_fpu_operand_size  = size;
        bus.cpu_fpu_is_integer    = isint;
        bus.cpu_fpu_is_bcd        = isbcd;
        tick();
        bus.cpu_fpu_instr_valid   = 1'b0;
        m_op = op; m_modrm = modrm; m_mem = mem; m_size = size; m_int = isint; m_bcd = isbcd;
        m_dready = 1'b0;
        check("acc.ack", bus.cpu_fpu_instr_ack, 1'b1);
        check("acc.busy", bus.cpu_fpu_busy, 1'b1);
        check("acc.ready", bus.cpu_fpu_ready, 1'b0);
        check("acc.dready", bus.cpu_fpu_data_ready, 1'b0);
        check_format("acc");
        tick();
        check("post.ack", bus.cpu_fpu_instr_ack, 1'b0);
        if (mem) begin
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                check("wdata.start", bus.fpu_start, 1'b0);
                check("wdata.busy", bus.cpu_fpu_busy, 1'b1);
                tick();
            end
            bus.cpu_fpu_data_write = 1'b1;
            bus.cpu_fpu_data_in    = opnd;
            tick();
            bus.cpu_fpu_data_write = 1'b0;
            m_opnd = opnd;
            check("wdata.opnd", bus.fpu_operand_data, m_opnd);
        end
        check("exec.start", bus.fpu_start, 1'b1);
        check("exec.op", bus.fpu_operation, m_op);
        tick();
        check("done.start_drop", bus.fpu_start, 1'b0);
        // Offers that must be ignored while the core is running
        bus.cpu_fpu_instr_valid = 1'b1;
        bus.cpu_fpu_opcode      = ~op;
        bus.cpu_fpu_data_write  = 1'b1;
        bus.cpu_fpu_data_in     = ~opnd;
        tick();
        bus.cpu_fpu_instr_valid = 1'b0;
        bus.cpu_fpu_data_write  = 1'b0;
        check("ign.op", bus.fpu_operation, m_op);
        check("ign.opnd", bus.fpu_operand_data, m_opnd);
        check("ign.ack", bus.cpu_fpu_instr_ack, 1'b0);
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            check("wdone.busy", bus.cpu_fpu_busy, 1'b1);
            check("wdone.start", bus.fpu_start, 1'b0);
            tick();
        end
        bus.fpu_operation_complete = 1'b1;
        bus.fpu_result_data        = result;
        bus.fpu_status             = status;
        bus.fpu_error              = err;
        if (cw_same) begin
            bus.cpu_fpu_control_word = cw_val;
            bus.cpu_fpu_ctrl_write   = 1'b1;
        end
        tick();
        bus.fpu_operation_complete = 1'b0;
        bus.fpu_error              = 1'b0;
        bus.cpu_fpu_ctrl_write     = 1'b0;
        m_data_out = result; m_status = status; m_dready = 1'b1;
        if (cw_same) m_exc = 1'b0;
        else if (err && ((status[5:0] & ~m_cw[5:0]) != 6'd0)) m_exc = 1'b1;
        if (cw_same) m_cw = cw_val;
        check_idle("cmpl");
        check_format("hold");
        // A completion while idle must not disturb the latched result
        bus.fpu_operation_complete = 1'b1;
        bus.fpu_result_data        = ~result;
        tick();
        bus.fpu_operation_complete = 1'b0;
        check("ign.cmpl_dout", bus.cpu_fpu_data_out, m_data_out);
        check("ign.cmpl_ready", bus.cpu_fpu_ready, 1'b1);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_idle("reset");
        check_format("reset");
        check("reset.update", bus.fpu_control_update, 1'b0);
        check("reset.ack", bus.cpu_fpu_instr_ack, 1'b0);

        bus.cpu_fpu_wait = 1'b1;
        tick();
        check("wait.ready", bus.cpu_fpu_ready, 1'b1);
        bus.cpu_fpu_wait = 1'b0;

        run_instr(8'hD8, 8'hC0, 1'b0, 2'd0, 1'b0, 1'b0, 80'h0, 80'h1234, 16'h0000, 1'b0, 1'b0, 16'h0);
        run_instr(8'hD8, 8'h06, 1'b1, 2'd1, 1'b0, 1'b0, 80'h3F800000, 80'h4000, 16'h0000, 1'b0, 1'b0, 16'h0);
        write_cw(16'h0000);
        write_cw(16'h037F);
        run_instr(8'hDA, 8'h06, 1'b1, 2'd1, 1'b1, 1'b0, 80'h5, 80'h3FFF8000000000000000, 16'h0000, 1'b0, 1'b0, 16'h0);
        check("da.dready", bus.cpu_fpu_data_ready, 1'b1);
        read_result();

        write_cw(16'h0000);
        run_instr(8'hD9, 8'hE8, 1'b0, 2'd0, 1'b0, 1'b0, 80'h0, 80'h1, 16'h0001, 1'b1, 1'b0, 16'h0);
        check("err.exc", bus.cpu_fpu_exception, 1'b1);
        check("err.irq", bus.cpu_fpu_irq, 1'b1);
        write_cw(16'h037F);
        run_instr(8'hD9, 8'hE8, 1'b0, 2'd0, 1'b0, 1'b0, 80'h0, 80'h2, 16'h0001, 1'b1, 1'b0, 16'h0);
        check("masked.exc", bus.cpu_fpu_exception, 1'b0);

        // Unmasked exception with IEM set: exception visible, interrupt suppressed
        write_cw(16'h00BE);
        run_instr(8'hDC, 8'h01, 1'b0, 2'd0, 1'b0, 1'b0, 80'h0, 80'h3, 16'h0041, 1'b1, 1'b0, 16'h0);
        check("iem.exc", bus.cpu_fpu_exception, 1'b1);
        check("iem.irq", bus.cpu_fpu_irq, 1'b0);
        write_cw(16'h037F);

        // Reset while waiting for an operand aborts to a clean idle state
        write_cw(16'h0000);
        bus.cpu_fpu_instr_valid   = 1'b1;
        bus.cpu_fpu_opcode        = 8'hDD;
        bus.cpu_fpu_has_memory_op = 1'b1;
        tick();
        bus.cpu_fpu_instr_valid   = 1'b0;
        bus.cpu_fpu_has_memory_op = 1'b0;
        tick();
        check("abort.busy_before", bus.cpu_fpu_busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check_idle("abort");
        check_format("abort");

        for (int t = 0; t < 40; t++) begin
            logic [79:0] opnd, result;
            logic [15:0] status, cw_val;
            logic        err, cw_same;
            opnd    = {$urandom, $urandom, $urandom};
            result  = {$urandom, $urandom, $urandom};
            status  = 16'($urandom);
            err     = ($urandom_range(0, 2) != 0);
            cw_same = ($urandom_range(0, 7) == 0);
            cw_val  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) write_cw(16'($urandom));
            run_instr(8'hD8 + 8'($urandom_range(0, 7)), 8'($urandom), 1'($urandom),
                      2'($urandom), 1'($urandom), 1'($urandom),
                      opnd, result, status, err, cw_same, cw_val);
            if ($urandom_range(0, 1) == 1) read_result();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
